// File: rtl/id_stage.sv
// id_stage: RV32I OP/OP-IMM decode, 32x32 register file and one-entry ALU pipeline register.
module id_stage #(
   parameter bit BYPASS_EN = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        if_valid,
   output logic        if_ready,
   input  logic [31:0] if_instr,
   input  logic        flush,
   output logic        ex_valid,
   input  logic        ex_ready,
   output logic [2:0]  funct3,
   output logic [6:0]  funct7,
   output logic        src_sel,
   output logic        alu_en,
   output logic [31:0] reg_data_1,
   output logic [31:0] reg_data_2,
   output logic [31:0] immediate,
   output logic [4:0]  rd_addr,
   output logic        rd_we,
   output logic        illegal,
   input  logic        wb_we,
   input  logic [4:0]  wb_addr,
   input  logic [31:0] wb_data
);

   localparam int unsigned XLEN = 32;
   localparam int unsigned AW   = 5;
   localparam int unsigned NREG = 32;
   localparam logic [6:0] OPC_OP    = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM = 7'b0010011;
   localparam logic [6:0] F7_ZERO   = 7'b0000000;
   localparam logic [6:0] F7_ALT    = 7'b0100000;

   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

   state_t            state_q, state_d;
   logic [2:0]        funct3_q, funct3_d;
   logic [6:0]        funct7_q, funct7_d;
   logic              src_sel_q, src_sel_d;
   logic              alu_en_q, alu_en_d;
   logic [XLEN-1:0]   reg_data_1_q, reg_data_1_d;
   logic [XLEN-1:0]   reg_data_2_q, reg_data_2_d;
   logic [XLEN-1:0]   immediate_q, immediate_d;
   logic [AW-1:0]     rd_addr_q, rd_addr_d;
   logic              rd_we_q, rd_we_d;
   logic              illegal_q, illegal_d;
   logic [AW-1:0]     rs1_q, rs1_d;
   logic [AW-1:0]     rs2_q, rs2_d;

   logic [XLEN-1:0]   rf_q [NREG];
   logic              rf_we;

   logic [6:0]        opcode, dec_f7_raw, dec_f7;
   logic [2:0]        dec_f3;
   logic [AW-1:0]     dec_rs1, dec_rs2, dec_rd;
   logic [XLEN-1:0]   rs1_val, rs2_val, dec_imm, dec_d1, dec_d2;
   logic              dec_legal, dec_src;
   logic              accept, drain, hold;

   assign ex_valid   = (state_q == FULL);
   assign if_ready   = !ex_valid | ex_ready;
   assign accept     = if_valid & if_ready;
   assign drain      = ex_valid & ex_ready;
   assign hold       = ex_valid & !ex_ready;

   assign funct3     = funct3_q;
   assign funct7     = funct7_q;
   assign src_sel    = src_sel_q;
   assign alu_en     = alu_en_q;
   assign reg_data_1 = reg_data_1_q;
   assign reg_data_2 = reg_data_2_q;
   assign immediate  = immediate_q;
   assign rd_addr    = rd_addr_q;
   assign rd_we      = rd_we_q;
   assign illegal    = illegal_q;

   assign opcode     = if_instr[6:0];
   assign dec_rd     = if_instr[11:7];
   assign dec_f3     = if_instr[14:12];
   assign dec_rs1    = if_instr[19:15];
   assign dec_rs2    = if_instr[24:20];
   assign dec_f7_raw = if_instr[31:25];

   // Regfile write port; x0 is never written
   assign rf_we = wb_we & (wb_addr != '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(NREG); i++) rf_q[i] <= '0;
      end else if (rf_we) begin
         rf_q[wb_addr] <= wb_data;
      end
   end

   // Source reads, with optional forwarding of a same-cycle writeback
   assign rs1_val = (dec_rs1 == '0) ? '0 :
                    (BYPASS_EN && wb_we && (wb_addr == dec_rs1)) ? wb_data : rf_q[dec_rs1];
   assign rs2_val = (dec_rs2 == '0) ? '0 :
                    (BYPASS_EN && wb_we && (wb_addr == dec_rs2)) ? wb_data : rf_q[dec_rs2];

   // Instruction decode; illegal encodings produce all-zero fields
   always_comb begin
      dec_legal = 1'b0;
      dec_src   = 1'b0;
      dec_f7    = '0;
      dec_imm   = '0;
      dec_d1    = '0;
      dec_d2    = '0;
      if (opcode == OPC_OP) begin
         dec_legal = (dec_f7_raw == F7_ZERO) ||
                     ((dec_f7_raw == F7_ALT) && ((dec_f3 == 3'b000) || (dec_f3 == 3'b101)));
         if (dec_legal) begin
            dec_src = 1'b1;
            dec_f7  = dec_f7_raw;
            dec_d1  = rs1_val;
            dec_d2  = rs2_val;
         end
      end else if (opcode == OPC_OPIMM) begin
         case (dec_f3)
            3'b001:  dec_legal = (dec_f7_raw == F7_ZERO);
            3'b101:  dec_legal = (dec_f7_raw == F7_ZERO) || (dec_f7_raw == F7_ALT);
            default: dec_legal = 1'b1;
         endcase
         if (dec_legal) begin
            dec_f7  = ((dec_f3 == 3'b001) || (dec_f3 == 3'b101)) ? dec_f7_raw : F7_ZERO;
            dec_imm = {{(XLEN-12){if_instr[31]}}, if_instr[31:20]};
            dec_d1  = rs1_val;
         end
      end
   end

   // Pipeline register next state: flush, capture, drain or hold with operand refresh
   always_comb begin
      state_d      = state_q;
      funct3_d     = funct3_q;
      funct7_d     = funct7_q;
      src_sel_d    = src_sel_q;
      alu_en_d     = alu_en_q;
      reg_data_1_d = reg_data_1_q;
      reg_data_2_d = reg_data_2_q;
      immediate_d  = immediate_q;
      rd_addr_d    = rd_addr_q;
      rd_we_d      = rd_we_q;
      illegal_d    = illegal_q;
      rs1_d        = rs1_q;
      rs2_d        = rs2_q;
      if (flush) begin
         state_d = EMPTY;
      end else if (accept) begin
         state_d      = FULL;
         alu_en_d     = dec_legal;
         illegal_d    = !dec_legal;
         funct3_d     = dec_legal ? dec_f3 : 3'b000;
         funct7_d     = dec_f7;
         src_sel_d    = dec_src;
         reg_data_1_d = dec_d1;
         reg_data_2_d = dec_d2;
         immediate_d  = dec_imm;
         rd_addr_d    = dec_legal ? dec_rd : '0;
         rd_we_d      = dec_legal && (dec_rd != '0);
         rs1_d        = dec_legal ? dec_rs1 : '0;
         rs2_d        = (dec_legal && dec_src) ? dec_rs2 : '0;
      end else if (drain) begin
         state_d = EMPTY;
      end else if (BYPASS_EN && hold && alu_en_q && rf_we) begin
         if (wb_addr == rs1_q) reg_data_1_d = wb_data;
         if (src_sel_q && (wb_addr == rs2_q)) reg_data_2_d = wb_data;
      end
   end

   // Pipeline register flops
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= EMPTY;
         funct3_q     <= '0;
         funct7_q     <= '0;
         src_sel_q    <= 1'b0;
         alu_en_q     <= 1'b0;
         reg_data_1_q <= '0;
         reg_data_2_q <= '0;
         immediate_q  <= '0;
         rd_addr_q    <= '0;
         rd_we_q      <= 1'b0;
         illegal_q    <= 1'b0;
         rs1_q        <= '0;
         rs2_q        <= '0;
      end else begin
         state_q      <= state_d;
         funct3_q     <= funct3_d;
         funct7_q     <= funct7_d;
         src_sel_q    <= src_sel_d;
         alu_en_q     <= alu_en_d;
         reg_data_1_q <= reg_data_1_d;
         reg_data_2_q <= reg_data_2_d;
         immediate_q  <= immediate_d;
         rd_addr_q    <= rd_addr_d;
         rd_we_q      <= rd_we_d;
         illegal_q    <= illegal_d;
         rs1_q        <= rs1_d;
         rs2_q        <= rs2_d;
      end
   end

endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed scenarios plus randomized traffic against a behavioural decode/regfile model.
module tb_id_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        if_valid, if_ready, flush, ex_valid, ex_ready;
   logic [31:0] if_instr;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic        src_sel, alu_en, rd_we, illegal;
   logic [31:0] reg_data_1, reg_data_2, immediate;
   logic [4:0]  rd_addr;
   logic        wb_we;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;

   id_stage dut (
      .clk(clk), .rst_n(rst_n),
      .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr),
      .flush(flush), .ex_valid(ex_valid), .ex_ready(ex_ready),
      .funct3(funct3), .funct7(funct7), .src_sel(src_sel), .alu_en(alu_en),
      .reg_data_1(reg_data_1), .reg_data_2(reg_data_2), .immediate(immediate),
      .rd_addr(rd_addr), .rd_we(rd_we), .illegal(illegal),
      .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        v;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic        src;
      logic        alu;
      logic [31:0] d1;
      logic [31:0] d2;
      logic [31:0] imm;
      logic [4:0]  rd;
      logic        we;
      logic        ill;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
   } ent_t;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;
   logic [31:0] rf [32];
   ent_t        m;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Register read as seen at capture time, including same-cycle writeback forwarding
   function automatic logic [31:0] read_reg(input logic [4:0] r, input logic we,
                                            input logic [4:0] wa, input logic [31:0] wd);
      if (r == 5'd0) return 32'd0;
      if (we && wa == r) return wd;
      return rf[r];
   endfunction

   // Decode rules stated directly from the RV32I OP/OP-IMM subset
   function automatic ent_t decode(input logic [31:0] i, input logic we,
                                   input logic [4:0] wa, input logic [31:0] wd);
      ent_t e;
      logic [6:0] opc, f7;
      logic [2:0] f3;
      bit is_op, is_imm, ok, shift;
      e = '0;
      opc = i[6:0]; f3 = i[14:12]; f7 = i[31:25];
      is_op  = (opc == 7'h33);
      is_imm = (opc == 7'h13);
      shift  = (f3 == 3'd1) || (f3 == 3'd5);
      if (is_op)
         ok = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
      else if (is_imm)
         ok = !shift || (f7 == 7'h00) || (f3 == 3'd5 && f7 == 7'h20);
      else
         ok = 1'b0;
      if (!ok) begin
         e.ill = 1'b1;
         return e;
      end
      e.alu = 1'b1;
      e.f3  = f3;
      e.rd  = i[11:7];
      e.we  = (i[11:7] != 5'd0);
      e.rs1 = i[19:15];
      e.d1  = read_reg(i[19:15], we, wa, wd);
      if (is_op) begin
         e.src = 1'b1;
         e.f7  = f7;
         e.rs2 = i[24:20];
         e.d2  = read_reg(i[24:20], we, wa, wd);
      end else begin
         e.f7  = shift ? f7 : 7'h00;
         e.imm = 32'($signed(i[31:20]));
      end
      return e;
   endfunction

   task automatic model_reset();
      m = '0;
      for (int k = 0; k < 32; k++) rf[k] = 32'd0;
   endtask

   task automatic check_zero_outputs();
      check("rst_ex_valid", 32'(ex_valid), 32'd0);
      check("rst_funct3", 32'(funct3), 32'd0);
      check("rst_funct7", 32'(funct7), 32'd0);
      check("rst_src_sel", 32'(src_sel), 32'd0);
      check("rst_alu_en", 32'(alu_en), 32'd0);
      check("rst_data1", reg_data_1, 32'd0);
      check("rst_data2", reg_data_2, 32'd0);
      check("rst_imm", immediate, 32'd0);
      check("rst_rd_addr", 32'(rd_addr), 32'd0);
      check("rst_rd_we", 32'(rd_we), 32'd0);
      check("rst_illegal", 32'(illegal), 32'd0);
   endtask

   task automatic check_outputs();
      check("ex_valid", 32'(ex_valid), 32'(m.v));
      if (m.v) begin
         check("illegal", 32'(illegal), 32'(m.ill));
         check("alu_en", 32'(alu_en), 32'(m.alu));
         check("rd_we", 32'(rd_we), 32'(m.we));
         check("funct3", 32'(funct3), 32'(m.f3));
         check("funct7", 32'(funct7), 32'(m.f7));
         check("src_sel", 32'(src_sel), 32'(m.src));
         check("reg_data_1", reg_data_1, m.d1);
         check("reg_data_2", reg_data_2, m.d2);
         check("immediate", immediate, m.imm);
         if (!m.ill) check("rd_addr", 32'(rd_addr), 32'(m.rd));
      end
   endtask

   // One clock: drive inputs, predict the next entry, clock, compare
   task automatic step(input logic iv, input logic [31:0] ins, input logic er, input logic fl,
                       input logic we, input logic [4:0] wa, input logic [31:0] wd);
      ent_t nx;
      logic rdy;
      if_valid = iv; if_instr = ins; ex_ready = er; flush = fl;
      wb_we = we; wb_addr = wa; wb_data = wd;
      #1;
      rdy = !m.v || er;
      check("if_ready", 32'(if_ready), 32'(rdy));
      nx = m;
      if (fl) nx.v = 1'b0;
      else if (iv && rdy) begin
         nx = decode(ins, we, wa, wd);
         nx.v = 1'b1;
      end else if (m.v && er) nx.v = 1'b0;
      else if (m.v && m.alu && we && wa != 5'd0) begin
         if (wa == m.rs1) nx.d1 = wd;
         if (m.src && wa == m.rs2) nx.d2 = wd;
      end
      @(posedge clk);
      #1;
      if (we && wa != 5'd0) rf[wa] = wd;
      m = nx;
      check_outputs();
   endtask

   // Asynchronous reset asserted mid-cycle, released before the next edge
   task automatic reset_mid();
      rst_n = 1'b0;
      #1;
      model_reset();
      check_zero_outputs();
      #1;
      rst_n = 1'b1;
   endtask

   function automatic logic [31:0] rand_instr();
      logic [31:0] i;
      logic [6:0]  f7;
      int unsigned sel, f7sel;
      sel   = $urandom_range(0, 9);
      f7sel = $urandom_range(0, 3);
      f7 = (f7sel == 0) ? 7'h20 : (f7sel == 1) ? 7'($urandom) : 7'h00;
      i = {f7, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 3'($urandom),
           5'($urandom_range(0, 7)), 7'h33};
      if (sel >= 4 && sel <= 7) begin
         i[6:0] = 7'h13;
         if (sel == 7) i[24:20] = 5'($urandom);
      end else if (sel == 8) i = $urandom;
      else if (sel == 9) i = 32'h0000_0073;
      return i;
   endfunction

   initial begin
      rst_n = 1'b0;
      if_valid = 1'b0; if_instr = '0; ex_ready = 1'b0; flush = 1'b0;
      wb_we = 1'b0; wb_addr = '0; wb_data = '0;
      model_reset();
      @(posedge clk);
      #1;
      check_zero_outputs();
      rst_n = 1'b1;

      // 1: fill, reset mid-FULL, then read never-written registers
      step(1'b1, 32'h0020_81B3, 1'b0, 1'b0, 1'b1, 5'd1, 32'h55);
      step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
      reset_mid();
      step(1'b1, 32'h0020_81B3, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
      check("t1_data1", reg_data_1, 32'd0);
      check("t1_data2", reg_data_2, 32'd0);

      // 2: writes then ADD x3,x1,x2
      step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 5'd1, 32'd5);
      step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 5'd2, 32'd3);
      step(1'b1, 32'h0020_81B3, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
      check("t2_valid", 32'(ex_valid), 32'd1);
      check("t2_src_sel", 32'(src_sel), 32'd1);
      check("t2_funct7", 32'(funct7), 32'd0);
      check("t2_data1", reg_data_1, 32'd5);
      check("t2_data2", reg_data_2, 32'd3);
      check("t2_rd_addr", 32'(rd_addr), 32'd3);
      check("t2_rd_we", 32'(rd_we), 32'd1);

      // 3: ADDI x1,x0,-1
      step(1'b1, 32'hFFF0_0093, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
      check("t3_imm", immediate, 32'hFFFF_FFFF);
      check("t3_src_sel", 32'(src_sel), 32'd0);
      check("t3_data1", reg_data_1, 32'd0);
      check("t3_funct3", 32'(funct3), 32'd0);
      check("t3_funct7", 32'(funct7), 32'd0);

      // 4: SUB held three cycles while x1 is rewritten
      step(1'b1, 32'h4020_81B3, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
      step(1'b1, 32'h0000_0013, 1'b0, 1'b0, 1'b1, 5'd1, 32'd7);
      check("t4_if_ready", 32'(if_ready), 32'd0);
      step(1'b1, 32'h0000_0013, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
      step(1'b1, 32'h0000_0013, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
      check("t4_funct7", 32'(funct7), 32'h20);
      check("t4_data1", reg_data_1, 32'd7);
      step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);

      // 5: capture with same-edge write of x2, then flush with a valid instruction
      step(1'b1, 32'h0020_81B3, 1'b1, 1'b0, 1'b1, 5'd2, 32'd9);
      check("t5_data2", reg_data_2, 32'd9);
      step(1'b1, 32'hFFF0_0093, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0);
      check("t5_flush_valid", 32'(ex_valid), 32'd0);

      // 6: ECALL is illegal here; x0 stays zero after a write attempt
      step(1'b1, 32'h0000_0073, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
      check("t6_illegal", 32'(illegal), 32'd1);
      check("t6_alu_en", 32'(alu_en), 32'd0);
      check("t6_rd_we", 32'(rd_we), 32'd0);
      check("t6_valid", 32'(ex_valid), 32'd1);
      step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 5'd0, 32'h0000_DEAD);
      step(1'b1, 32'h0000_01B3, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
      check("t6_x0_data1", reg_data_1, 32'd0);
      check("t6_x0_data2", reg_data_2, 32'd0);

      // Randomized traffic with one mid-run reset
      for (int n = 0; n < 3000; n++) begin
         if (n == 1500) reset_mid();
         step(1'($urandom_range(0, 9) < 7), rand_instr(), 1'($urandom_range(0, 9) < 6),
              1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 1)),
              5'($urandom_range(0, 7)), $urandom);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
